// File: rtl/csr_regfile_ext.sv
// CSR register file with per-register RW/RO/WO/W1C access, byte strobes, a hardware update port and an interrupt.
// Bus requests are acknowledged one cycle later with registered read data and violation code.
module csr_regfile_ext #(
    parameter int                           REG_DW     = 32,
    parameter int                           REG_AW     = 6,
    parameter int                           NUM_REGS   = 16,
    parameter logic [2*NUM_REGS-1:0]        REG_ACCESS = '0,
    parameter logic [NUM_REGS*REG_DW-1:0]   RESET_VAL  = '0
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    input  logic [REG_AW-1:0]               reg_addr_i,
    input  logic [REG_DW-1:0]               reg_wdata_i,
    input  logic [REG_DW/8-1:0]             reg_wstrb_i,
    input  logic                            reg_write_i,
    input  logic                            reg_read_i,
    output logic                            reg_ack_o,
    output logic [REG_DW-1:0]               reg_rdata_o,
    output logic [1:0]                      access_violation_o,
    input  logic [NUM_REGS-1:0]             hw_we_i,
    input  logic [NUM_REGS*REG_DW-1:0]      hw_wdata_i,
    output logic [NUM_REGS*REG_DW-1:0]      hw_rdata_o,
    output logic                            irq_o
);

    localparam int               NB     = REG_DW / 8;
    localparam logic [1:0]       ACC_RW  = 2'b00;
    localparam logic [1:0]       ACC_RO  = 2'b01;
    localparam logic [1:0]       ACC_WO  = 2'b10;
    localparam logic [1:0]       ACC_W1C = 2'b11;
    localparam logic [REG_AW:0]  NREGS_W = (REG_AW+1)'(NUM_REGS);

    logic [REG_DW-1:0] regs_q [NUM_REGS];
    logic [REG_DW-1:0] regs_d [NUM_REGS];

    logic              ack_q, ack_d;
    logic [REG_DW-1:0] rdata_q, rdata_d;
    logic [1:0]        viol_q, viol_d;

    logic              in_range;
    logic [REG_DW-1:0] wmask;
    logic [REG_DW-1:0] sel_val;
    logic [1:0]        sel_mode;
    logic              irq_c;

    assign in_range = ({1'b0, reg_addr_i} < NREGS_W);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{reg_wstrb_i[b]}};
        end
    end

    // Next-state per register; for W1C the hardware set is applied after the clear so set wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            logic sw_hit;
            sw_hit    = reg_write_i && in_range && (reg_addr_i == REG_AW'(i));
            regs_d[i] = regs_q[i];
            case (REG_ACCESS[2*i +: 2])
                ACC_RW, ACC_WO: begin
                    if (sw_hit) regs_d[i] = (regs_q[i] & ~wmask) | (reg_wdata_i & wmask);
                end
                ACC_RO: begin
                    if (hw_we_i[i]) regs_d[i] = hw_wdata_i[i*REG_DW +: REG_DW];
                end
                default: begin
                    if (sw_hit)     regs_d[i] = regs_q[i] & ~(reg_wdata_i & wmask);
                    if (hw_we_i[i]) regs_d[i] = regs_d[i] | hw_wdata_i[i*REG_DW +: REG_DW];
                end
            endcase
        end
    end

    always_comb begin
        sel_val  = '0;
        sel_mode = ACC_RW;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_addr_i == REG_AW'(i)) begin
                sel_val  = regs_q[i];
                sel_mode = REG_ACCESS[2*i +: 2];
            end
        end
    end

    always_comb begin
        ack_d   = reg_write_i || reg_read_i;
        rdata_d = '0;
        viol_d  = 2'd0;
        if (ack_d) begin
            if (!in_range) begin
                viol_d = 2'd3;
            end else if (reg_write_i && sel_mode == ACC_RO) begin
                viol_d = 2'd1;
            end else if (reg_read_i && sel_mode == ACC_WO) begin
                viol_d = 2'd2;
            end
            if (reg_read_i && in_range && sel_mode != ACC_WO) rdata_d = sel_val;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[i*REG_DW +: REG_DW];
            end
            ack_q   <= 1'b0;
            rdata_q <= '0;
            viol_q  <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            viol_q  <= viol_d;
        end
    end

    always_comb begin
        irq_c = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hw_rdata_o[i*REG_DW +: REG_DW] = regs_q[i];
            if (REG_ACCESS[2*i +: 2] == ACC_W1C) irq_c = irq_c | (|regs_q[i]);
        end
    end

    assign irq_o              = irq_c;
    assign reg_ack_o          = ack_q;
    assign reg_rdata_o        = rdata_q;
    assign access_violation_o = viol_q;

endmodule

// File: tb/tb_csr_regfile_ext.sv
// Directed vector bench for csr_regfile_ext: reg0 RW, reg1 RO, reg2 WO, reg3 W1C, reg4 RW with a nonzero reset value.
module tb_csr_regfile_ext;

    localparam int           DW = 32;
    localparam int           AW = 6;
    localparam int           NR = 16;
    localparam logic [31:0]  ACC = 32'h0000_00E4;
    localparam logic [NR*DW-1:0] RV = {{(NR*DW-32){1'b0}}, 32'hDEAD_BEEF} << (4*DW);

    logic             clk;
    logic             arst;
    logic [AW-1:0]    reg_addr;
    logic [DW-1:0]    reg_wdata;
    logic [DW/8-1:0]  reg_wstrb;
    logic             reg_write;
    logic             reg_read;
    logic             reg_ack;
    logic [DW-1:0]    reg_rdata;
    logic [1:0]       access_violation;
    logic [NR-1:0]    hw_we;
    logic [NR*DW-1:0] hw_wdata;
    logic [NR*DW-1:0] hw_rdata;
    logic             irq;

    csr_regfile_ext #(
        .REG_DW(DW), .REG_AW(AW), .NUM_REGS(NR), .REG_ACCESS(ACC), .RESET_VAL(RV)
    ) dut (
        .clk_i(clk), .arst_i(arst),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_wstrb_i(reg_wstrb),
        .reg_write_i(reg_write), .reg_read_i(reg_read),
        .reg_ack_o(reg_ack), .reg_rdata_o(reg_rdata), .access_violation_o(access_violation),
        .hw_we_i(hw_we), .hw_wdata_i(hw_wdata), .hw_rdata_o(hw_rdata), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [3:0]  hwe;
        logic [31:0] hwd;
        logic        ack;
        logic [31:0] rdata;
        logic [1:0]  viol;
        logic        irq;
    } vec_t;

    vec_t tbl[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    function automatic vec_t mk(logic wr, logic rd, logic [5:0] addr, logic [31:0] wd, logic [3:0] st,
                                logic [3:0] hwe, logic [31:0] hwd,
                                logic ack, logic [31:0] rdata, logic [1:0] viol, logic ir);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.st = st; v.hwe = hwe; v.hwd = hwd;
        v.ack = ack; v.rdata = rdata; v.viol = viol; v.irq = ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reg_write = 1'b0; reg_read = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wstrb = '0;
        hw_we = '0; hw_wdata = '0;
    endtask

    initial begin
        idle();
        arst = 1'b1;

        //  wr rd addr wdata         st     hwe      hwd           ack rdata         viol irq
        tbl.push_back(mk(1, 0, 0,  32'hAABBCCDD, 4'h3, 4'b0000, 32'h0,        1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 0,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0000CCDD, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        4'h0, 4'b0010, 32'h12345678, 0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 1,  32'hFFFFFFFF, 4'hF, 4'b0000, 32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(mk(0, 1, 1,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h12345678, 0, 0));
        tbl.push_back(mk(1, 0, 2,  32'h55,       4'hF, 4'b0000, 32'h0,        1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 2,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0,        2, 0));
        tbl.push_back(mk(0, 1, 20, 32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0,        3, 0));
        tbl.push_back(mk(1, 0, 20, 32'hFFFFFFFF, 4'hF, 4'b0000, 32'h0,        1, 32'h0,        3, 0));
        tbl.push_back(mk(1, 1, 20, 32'hFFFFFFFF, 4'hF, 4'b0000, 32'h0,        1, 32'h0,        3, 0));
        tbl.push_back(mk(0, 1, 0,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0000CCDD, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,        4'h0, 4'b1000, 32'h5,        0, 32'h0,        0, 1));
        tbl.push_back(mk(1, 0, 3,  32'h1,        4'hF, 4'b1000, 32'h8,        1, 32'h0,        0, 1));
        tbl.push_back(mk(0, 1, 3,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'hC,        0, 1));
        tbl.push_back(mk(1, 0, 3,  32'hC,        4'hF, 4'b0000, 32'h0,        1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 3,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0,        0, 0));
        tbl.push_back(mk(1, 0, 3,  32'h2,        4'hF, 4'b1000, 32'h2,        1, 32'h0,        0, 1));
        tbl.push_back(mk(0, 1, 3,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h2,        0, 1));
        tbl.push_back(mk(1, 0, 0,  32'h11,       4'hF, 4'b0000, 32'h0,        1, 32'h0,        0, 1));
        tbl.push_back(mk(1, 1, 0,  32'h22,       4'hF, 4'b0000, 32'h0,        1, 32'h11,       0, 1));
        tbl.push_back(mk(0, 1, 0,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h22,       0, 1));
        tbl.push_back(mk(1, 0, 1,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h0,        1, 1));
        tbl.push_back(mk(1, 1, 2,  32'h77,       4'hF, 4'b0000, 32'h0,        1, 32'h0,        2, 1));
        tbl.push_back(mk(1, 1, 1,  32'hFFFFFFFF, 4'hF, 4'b0000, 32'h0,        1, 32'h12345678, 1, 1));
        tbl.push_back(mk(0, 1, 0,  32'h0,        4'h0, 4'b0001, 32'hFFFF,     1, 32'h22,       0, 1));
        tbl.push_back(mk(0, 1, 0,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h22,       0, 1));
        tbl.push_back(mk(1, 0, 3,  32'h2,        4'h2, 4'b0000, 32'h0,        1, 32'h0,        0, 1));
        tbl.push_back(mk(0, 1, 3,  32'h0,        4'h0, 4'b0000, 32'h0,        1, 32'h2,        0, 1));

        repeat (2) @(negedge clk);
        chk("reset ack",   {31'b0, reg_ack}, 32'h0);
        chk("reset rdata", reg_rdata, 32'h0);
        chk("reset viol",  {30'b0, access_violation}, 32'h0);
        chk("reset irq",   {31'b0, irq}, 32'h0);
        chk("reset reg4",  hw_rdata[4*DW +: DW], 32'hDEADBEEF);
        chk("reset reg0",  hw_rdata[0 +: DW], 32'h0);
        arst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            reg_write = tbl[k].wr;
            reg_read  = tbl[k].rd;
            reg_addr  = tbl[k].addr;
            reg_wdata = tbl[k].wd;
            reg_wstrb = tbl[k].st;
            hw_we     = {12'b0, tbl[k].hwe};
            hw_wdata  = {NR{tbl[k].hwd}};
            @(negedge clk);
            chk($sformatf("v%0d ack", k),   {31'b0, reg_ack}, {31'b0, tbl[k].ack});
            chk($sformatf("v%0d rdata", k), reg_rdata, tbl[k].rdata);
            chk($sformatf("v%0d viol", k),  {30'b0, access_violation}, {30'b0, tbl[k].viol});
            chk($sformatf("v%0d irq", k),   {31'b0, irq}, {31'b0, tbl[k].irq});
        end

        idle();
        @(negedge clk);
        chk("idle ack",  {31'b0, reg_ack}, 32'h0);
        chk("hw reg0",   hw_rdata[0*DW +: DW], 32'h22);
        chk("hw reg1",   hw_rdata[1*DW +: DW], 32'h12345678);
        chk("hw reg2",   hw_rdata[2*DW +: DW], 32'h77);
        chk("hw reg3",   hw_rdata[3*DW +: DW], 32'h2);
        chk("hw reg4",   hw_rdata[4*DW +: DW], 32'hDEADBEEF);

        // Reset asserted while a request is on the bus: request is dropped.
        reg_write = 1'b1; reg_read = 1'b1; reg_addr = 6'd0; reg_wdata = 32'hFFFFFFFF; reg_wstrb = 4'hF;
        #2 arst = 1'b1;
        @(negedge clk);
        chk("mid-reset ack",   {31'b0, reg_ack}, 32'h0);
        chk("mid-reset rdata", reg_rdata, 32'h0);
        chk("mid-reset viol",  {30'b0, access_violation}, 32'h0);
        chk("mid-reset irq",   {31'b0, irq}, 32'h0);
        chk("mid-reset regs",  {31'b0, (hw_rdata !== RV)}, 32'h0);
        idle();
        arst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post-reset ack", {31'b0, reg_ack}, 32'h0);
        end
        chk("post-reset reg0", hw_rdata[0 +: DW], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
